// File: rtl/logic_unit_arbiter4.sv
// Round-robin arbiter sharing one 32-bit bitwise logic unit among four requesters.
// Optional statistics outputs (grant_cnt, stall) are enabled by defining LU_ARB_STATS_EN.
module logic_unit_arbiter4 #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [3*NREQ-1:0]   op,
  input  logic [W*NREQ-1:0]   a,
  input  logic [W*NREQ-1:0]   b,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic [W-1:0]        result,
  output logic                result_valid,
  output logic [1:0]          result_id
`ifdef LU_ARB_STATS_EN
  ,
  output logic [15:0]         grant_cnt,
  output logic                stall
`endif
);

  // Handshake: a requester holds req[i]/op/a/b until it sees gnt[i] high for one
  // cycle; operands are captured on that grant edge, and result/result_id are
  // valid in the single cycle result_valid is high, holding until the next one.

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [1:0]      rr_q, rr_d;
  logic [1:0]      id_q, id_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]    res_q, res_d;
  logic [1:0]      rid_q, rid_d;
  logic            rv_q, rv_d;

  logic [2:0]      op_arr [NREQ];
  logic [W-1:0]    a_arr  [NREQ];
  logic [W-1:0]    b_arr  [NREQ];
  logic [1:0]      win;
  logic [1:0]      idx;
  logic            found;

  function automatic logic [W-1:0] lu_f(input logic [2:0] o,
                                        input logic [W-1:0] x,
                                        input logic [W-1:0] y);
    logic [W-1:0] r;
    case (o)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x ^ y);
      3'b100:  r = ~x;
      3'b101:  r = ~(x & y);
      3'b110:  r = ~(x | y);
      default: r = x;
    endcase
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = op[3*i +: 3];
      a_arr[i]  = a[W*i +: W];
      b_arr[i]  = b[W*i +: W];
    end
  end

  // First requester at or after rr_q, wrapping modulo 4.
  always_comb begin
    win   = rr_q;
    idx   = rr_q;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    gnt_d   = '0;
    res_d   = res_q;
    rid_d   = rid_q;
    rv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          id_d       = win;
          op_d       = op_arr[win];
          a_d        = a_arr[win];
          b_d        = b_arr[win];
          rr_d       = win + 2'd1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d   = lu_f(op_q, a_q, b_q);
        rid_d   = id_q;
        rv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      res_q   <= '0;
      rid_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gnt_q   <= gnt_d;
      res_q   <= res_d;
      rid_q   <= rid_d;
      rv_q    <= rv_d;
    end
  end

  assign gnt          = gnt_q;
  assign busy         = (state_q == EXEC);
  assign result       = res_q;
  assign result_valid = rv_q;
  assign result_id    = rid_q;

`ifdef LU_ARB_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && found && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign grant_cnt = cnt_q;
  assign stall     = |(req & ~gnt_q);
`endif

endmodule

// File: tb/tb_logic_unit_arbiter4.sv
// Bench for logic_unit_arbiter4: directed steps plus randomized traffic checked
// against a transaction-level round-robin model with an expected-result queue.
module tb_logic_unit_arbiter4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [3:0]   req;
  logic [11:0]  op;
  logic [127:0] a, b;
  logic [3:0]   gnt;
  logic         busy;
  logic [31:0]  result;
  logic         result_valid;
  logic [1:0]   result_id;
`ifdef LU_ARB_STATS_EN
  logic [15:0]  grant_cnt;
  logic         stall;
`endif

  logic_unit_arbiter4 dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .op           (op),
    .a            (a),
    .b            (b),
    .gnt          (gnt),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_id    (result_id)
`ifdef LU_ARB_STATS_EN
    ,
    .grant_cnt    (grant_cnt),
    .stall        (stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_ptr;
  bit          m_exec;
  int          m_cnt;
  logic [33:0] exp_q[$];
  logic [3:0]  e_gnt;
  logic        e_busy, e_rv;
  logic [31:0] e_res;
  logic [1:0]  e_rid;

  function automatic logic [31:0] ref_f(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x ^ y);
      3'd4:    return ~x;
      3'd5:    return ~(x & y);
      3'd6:    return ~(x | y);
      default: return x;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Predicts outputs after the coming edge from the inputs currently driven.
  task automatic model_step();
    int w;
    if (reset) begin
      m_ptr = 0; m_exec = 0; m_cnt = 0;
      exp_q.delete();
      e_gnt = 4'd0; e_busy = 1'b0; e_rv = 1'b0; e_res = 32'd0; e_rid = 2'd0;
    end else if (m_exec) begin
      {e_rid, e_res} = exp_q.pop_front();
      e_rv = 1'b1; e_gnt = 4'd0; e_busy = 1'b0; m_exec = 0;
    end else begin
      e_rv = 1'b0; e_gnt = 4'd0; e_busy = 1'b0;
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      if (w >= 0) begin
        e_gnt = 4'(1 << w);
        e_busy = 1'b1;
        exp_q.push_back({2'(w), ref_f(op[3*w +: 3], a[32*w +: 32], b[32*w +: 32])});
        m_ptr = (w + 1) % 4;
        m_exec = 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  // driver: one clock with full output comparison
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("gnt", {28'd0, gnt}, {28'd0, e_gnt});
    check("busy", {31'd0, busy}, {31'd0, e_busy});
    check("result_valid", {31'd0, result_valid}, {31'd0, e_rv});
    check("result", result, e_res);
    check("result_id", {30'd0, result_id}, {30'd0, e_rid});
`ifdef LU_ARB_STATS_EN
    check("grant_cnt", {16'd0, grant_cnt}, 32'(m_cnt));
    check("stall", {31'd0, stall}, {31'd0, |(req & ~e_gnt)});
`endif
  endtask

  logic [31:0] tbl [8];
  logic [3:0]  seen_gnt[$];
  logic [1:0]  seen_id[$];
  logic [3:0]  rot_exp [5];
  logic [2:0]  sv_op;
  logic [31:0] sv_a, sv_b;

  initial begin
    tbl = '{32'hAAAA_0000, 32'hFFFF_5555, 32'h5555_5555, 32'hAAAA_AAAA,
            32'h5555_AAAA, 32'h5555_FFFF, 32'h0000_AAAA, 32'hAAAA_5555};
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset held 2 cycles with all requesting
    reset = 1'b1; req = 4'hF; op = '0; a = '0; b = '0;
    step(); step();
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_rv", {31'd0, result_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    step();
    check("first_gnt", {28'd0, gnt}, 32'd1);
    req = 4'd0;
    step(); step();

    // single AND on requester 1
    req = 4'b0010; op[5:3] = 3'b000; a[63:32] = 32'hF0F0_1234; b[63:32] = 32'h0FF0_FFFF;
    step();
    check("and_gnt", {28'd0, gnt}, 32'b0010);
    req = 4'd0;
    step();
    check("and_rv", {31'd0, result_valid}, 32'd1);
    check("and_result", result, 32'h00F0_1234);
    check("and_id", {30'd0, result_id}, 32'd1);

    // all four requesting from a fresh pointer
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'hF; op = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int i = 0; i < 4; i++) begin
      a[32*i +: 32] = $urandom; b[32*i +: 32] = $urandom;
    end
    for (int c = 0; c < 10; c++) begin
      step();
      if (gnt != 4'd0) seen_gnt.push_back(gnt);
      if (result_valid) seen_id.push_back(result_id);
    end
    check("rot_ngnt", 32'(seen_gnt.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen_gnt.size(); i++)
      check("rot_gnt", {28'd0, seen_gnt[i]}, {28'd0, rot_exp[i]});
    for (int i = 0; i < 5 && i < seen_id.size(); i++)
      check("rot_id", {30'd0, seen_id[i]}, 32'(i % 4));
    req = 4'd0; step();

    // every opcode on requester 0
    for (int k = 0; k < 8; k++) begin
      req = 4'b0001; op[2:0] = 3'(k); a[31:0] = 32'hAAAA_5555; b[31:0] = 32'hFFFF_0000;
      step();
      req = 4'd0;
      step();
      check($sformatf("op%0d", k), result, tbl[k]);
    end

    // requester 2 changes operands after its grant
    req = 4'b0100; op[8:6] = 3'($urandom_range(0, 7)); a[95:64] = $urandom; b[95:64] = $urandom;
    sv_op = op[8:6]; sv_a = a[95:64]; sv_b = b[95:64];
    step();
    check("cap_gnt", {28'd0, gnt}, 32'b0100);
    req = 4'd0; a[95:64] = ~sv_a; b[95:64] = $urandom; op[8:6] = ~sv_op;
    step();
    check("cap_result", result, ref_f(sv_op, sv_a, sv_b));

    // reset during EXEC
    req = 4'b0010; step();
    reset = 1'b1; req = 4'd0; step();
    check("rst_exec_rv", {31'd0, result_valid}, 32'd0);
    reset = 1'b0; req = 4'hF; step();
    check("rst_exec_ptr", {28'd0, gnt}, 32'd1);
    req = 4'd0; step(); step();

`ifdef LU_ARB_STATS_EN
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'hF;
    for (int c = 0; c < 20; c++) begin
      step();
      check("stall_hi", {31'd0, stall}, 32'd1);
    end
    check("cnt_20", {16'd0, grant_cnt}, 32'd10);
    req = 4'd0; step(); step();
`endif

    // randomized traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      req = 4'($urandom_range(0, 15));
      op = 12'($urandom);
      for (int i = 0; i < 4; i++) begin
        a[32*i +: 32] = $urandom; b[32*i +: 32] = $urandom;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
